x2c_wr_arb: RTL and testbench

- Two-channel, frame-granular round-robin arbiter and write sequencer for the X2C transmit buffer (256-bit data FIFO, 32-bit ctrl FIFO, 32-bit byte-count FIFO).
- Grants one requester a whole frame only when the FIFOs have room for all of it.
- Streams the frame's words into the data/ctrl FIFOs, then writes the frame's byte-count descriptor, so the reader never sees a descriptor before its data.
- Rejects illegal frame lengths without writing anything.

---
 rtl/x2c_wr_arb.sv | 201 ++++++++++++++++++++
 tb/tb_x2c_wr_arb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/x2c_wr_arb.sv
// Two-channel frame-granular round-robin arbiter and write sequencer for the X2C transmit buffer.
// A frame is granted only when the data/ctrl and byte-count FIFOs can take all of it.
module x2c_wr_arb #(
    parameter int          DATA_DEPTH = 1024,
    parameter int          BCNT_DEPTH = 256,
    parameter logic [15:0] MAX_BYTES  = 16'd9600
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ch0_req,
    input  logic [31:0]  ch0_bcnt,
    input  logic [255:0] ch0_data,
    input  logic [31:0]  ch0_ctrl,
    input  logic         ch0_vld,
    output logic         ch0_rdy,
    output logic         ch0_done,
    output logic         ch0_err,
    input  logic         ch1_req,
    input  logic [31:0]  ch1_bcnt,
    input  logic [255:0] ch1_data,
    input  logic [31:0]  ch1_ctrl,
    input  logic         ch1_vld,
    output logic         ch1_rdy,
    output logic         ch1_done,
    output logic         ch1_err,
    input  logic [10:0]  data_usedw,
    input  logic [8:0]   bcnt_usedw,
    output logic [255:0] data_out,
    output logic [31:0]  ctrl_out,
    output logic         x_we,
    output logic [31:0]  x_byte_cnt,
    output logic         x_bcnt_we,
    output logic         busy
);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_CHK  = 5'b00010,
        S_XFER = 5'b00100,
        S_DESC = 5'b01000,
        S_DONE = 5'b10000
    } state_t;

    localparam logic [255:0] DATA_IDLE  = {32{8'h07}};
    localparam logic [31:0]  CTRL_IDLE  = 32'hffff_ffff;
    localparam logic [11:0]  DATA_LIMIT = 12'(DATA_DEPTH - 4);
    localparam logic [8:0]   BCNT_LIMIT = 9'(BCNT_DEPTH - 2);

    function automatic logic [10:0] words_of(input logic [15:0] bytes);
        logic [16:0] sum;
        sum = {1'b0, bytes} + 17'd31;
        return sum[15:5];
    endfunction

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          rr_last_q, rr_last_d;
    logic [31:0]   bcnt_q, bcnt_d;
    logic [10:0]   wc_q, wc_d;
    logic [10:0]   cnt_q, cnt_d;
    logic [255:0]  data_q, data_d;
    logic [31:0]   ctrl_q, ctrl_d;
    logic          we_q, we_d;
    logic [31:0]   byte_cnt_q, byte_cnt_d;
    logic          bcnt_we_q, bcnt_we_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [1:0]    ch_rdy;

    logic sel_vld;
    logic accept;
    logic len_bad;
    logic room_ok;
    logic grant;

    assign sel_vld = sel_q ? ch1_vld : ch0_vld;
    assign accept  = (state_q == S_XFER) && sel_vld;
    assign len_bad = (bcnt_q[15:0] == 16'd0) || (bcnt_q[15:0] > MAX_BYTES);
    assign room_ok = (({1'b0, data_usedw} + {1'b0, wc_q}) <= DATA_LIMIT) &&
                     (bcnt_usedw <= BCNT_LIMIT);
    // On a tie the channel that was not served last wins.
    assign grant   = (ch0_req && ch1_req) ? ~rr_last_q : ch1_req;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            rr_last_q  <= 1'b1;
            bcnt_q     <= '0;
            wc_q       <= '0;
            cnt_q      <= '0;
            data_q     <= DATA_IDLE;
            ctrl_q     <= CTRL_IDLE;
            we_q       <= 1'b0;
            byte_cnt_q <= '0;
            bcnt_we_q  <= 1'b0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_last_q  <= rr_last_d;
            bcnt_q     <= bcnt_d;
            wc_q       <= wc_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
            we_q       <= we_d;
            byte_cnt_q <= byte_cnt_d;
            bcnt_we_q  <= bcnt_we_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        sel_d     = sel_q;
        rr_last_d = rr_last_q;
        bcnt_d    = bcnt_q;
        wc_d      = wc_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (ch0_req || ch1_req) begin
                    sel_d   = grant;
                    bcnt_d  = grant ? ch1_bcnt : ch0_bcnt;
                    wc_d    = words_of(bcnt_d[15:0]);
                    cnt_d   = wc_d;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (len_bad) begin
                    rr_last_d = sel_q;
                    state_d   = S_IDLE;
                end else if (room_ok) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (accept) begin
                    cnt_d = cnt_q - 11'd1;
                    if (cnt_q == 11'd1) state_d = S_DESC;
                end
            end
            S_DESC: state_d = S_DONE;
            S_DONE: begin
                rr_last_d = sel_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ch_rdy     = 2'b00;
        we_d       = 1'b0;
        data_d     = data_q;
        ctrl_d     = ctrl_q;
        byte_cnt_d = byte_cnt_q;
        bcnt_we_d  = 1'b0;
        done_d     = 2'b00;
        err_d      = 2'b00;
        unique case (state_q)
            S_CHK: begin
                if (len_bad) err_d[sel_q] = 1'b1;
            end
            S_XFER: begin
                ch_rdy[sel_q] = 1'b1;
                if (accept) begin
                    we_d   = 1'b1;
                    data_d = sel_q ? ch1_data : ch0_data;
                    ctrl_d = sel_q ? ch1_ctrl : ch0_ctrl;
                end
            end
            S_DESC: begin
                bcnt_we_d  = 1'b1;
                byte_cnt_d = bcnt_q;
            end
            S_DONE: done_d[sel_q] = 1'b1;
            default: ;
        endcase
    end

    assign ch0_rdy    = ch_rdy[0];
    assign ch1_rdy    = ch_rdy[1];
    assign ch0_done   = done_q[0];
    assign ch1_done   = done_q[1];
    assign ch0_err    = err_q[0];
    assign ch1_err    = err_q[1];
    assign data_out   = data_q;
    assign ctrl_out   = ctrl_q;
    assign x_we       = we_q;
    assign x_byte_cnt = byte_cnt_q;
    assign x_bcnt_we  = bcnt_we_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_x2c_wr_arb.sv
// Directed bench for x2c_wr_arb: grant order, word/descriptor timing, rejects, room hold, vld gaps, reset abort.
module tb_x2c_wr_arb;

    logic         clk = 1'b0;
    logic         reset;
    logic         req [2];
    logic [31:0]  bcnt [2];
    logic [255:0] din [2];
    logic [31:0]  cin [2];
    logic         vld [2];
    logic         rdy [2];
    logic         done [2];
    logic         err [2];
    logic [10:0]  data_usedw;
    logic [8:0]   bcnt_usedw;
    logic [255:0] data_out;
    logic [31:0]  ctrl_out;
    logic         x_we;
    logic [31:0]  x_byte_cnt;
    logic         x_bcnt_we;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    int frame_no = 0;

    x2c_wr_arb dut (
        .clk        (clk),
        .reset      (reset),
        .ch0_req    (req[0]),
        .ch0_bcnt   (bcnt[0]),
        .ch0_data   (din[0]),
        .ch0_ctrl   (cin[0]),
        .ch0_vld    (vld[0]),
        .ch0_rdy    (rdy[0]),
        .ch0_done   (done[0]),
        .ch0_err    (err[0]),
        .ch1_req    (req[1]),
        .ch1_bcnt   (bcnt[1]),
        .ch1_data   (din[1]),
        .ch1_ctrl   (cin[1]),
        .ch1_vld    (vld[1]),
        .ch1_rdy    (rdy[1]),
        .ch1_done   (done[1]),
        .ch1_err    (err[1]),
        .data_usedw (data_usedw),
        .bcnt_usedw (bcnt_usedw),
        .data_out   (data_out),
        .ctrl_out   (ctrl_out),
        .x_we       (x_we),
        .x_byte_cnt (x_byte_cnt),
        .x_bcnt_we  (x_bcnt_we),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] word_of(input int ch, input int k);
        logic [255:0] r;
        logic [31:0]  w;
        w = 32'hD000_0000 | (32'(ch) << 24) | (32'(frame_no & 255) << 12) | 32'(k);
        for (int i = 0; i < 8; i++) r[32*i +: 32] = w ^ (32'(i) << 28);
        return r;
    endfunction

    function automatic logic [31:0] ctrl_of(input int ch, input int k);
        return 32'hC000_0000 | (32'(ch) << 20) | (32'(frame_no & 255) << 10) | 32'(k);
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_data_out"},  data_out,          {32{8'h07}});
        check({pfx, "_ctrl_out"},  256'(ctrl_out),    256'(32'hffff_ffff));
        check({pfx, "_x_we"},      256'(x_we),        256'(0));
        check({pfx, "_bcnt_we"},   256'(x_bcnt_we),   256'(0));
        check({pfx, "_byte_cnt"},  256'(x_byte_cnt),  256'(0));
        check({pfx, "_busy"},      256'(busy),        256'(0));
        check({pfx, "_rdy"},       256'({rdy[1], rdy[0]}),   256'(0));
        check({pfx, "_done"},      256'({done[1], done[0]}), 256'(0));
        check({pfx, "_err"},       256'({err[1], err[0]}),   256'(0));
    endtask

    // Waits (bounded) for the grant, streams nw words, then checks descriptor and done timing.
    task automatic serve(input int ch, input logic [31:0] b, input int nw, input bit gappy, input int exp_wait);
        int waited;
        logic [255:0] last_d;
        logic [31:0]  last_c;
        frame_no++;
        bcnt[ch] = b;
        req[ch]  = 1'b1;
        waited   = 0;
        while (!rdy[ch] && waited < 20) begin
            step();
            waited++;
        end
        if (!rdy[ch]) begin
            check($sformatf("grant_timeout_ch%0d", ch), 256'(0), 256'(1));
            req[ch] = 1'b0;
            return;
        end
        if (exp_wait >= 0) check("grant_latency", 256'(waited), 256'(exp_wait));
        check("other_rdy_low", 256'(rdy[1-ch]), 256'(0));
        last_d = '0;
        last_c = '0;
        for (int k = 0; k < nw; k++) begin
            if (gappy && k > 0) begin
                vld[ch] = 1'b0;
                step();
                check("gap_no_we",     256'(x_we),     256'(0));
                check("gap_hold_data", data_out,       last_d);
                check("gap_hold_ctrl", 256'(ctrl_out), 256'(last_c));
            end
            din[ch] = word_of(ch, k);
            cin[ch] = ctrl_of(ch, k);
            vld[ch] = 1'b1;
            step();
            last_d = word_of(ch, k);
            last_c = ctrl_of(ch, k);
            check("we",         256'(x_we),      256'(1));
            check("data",       data_out,        last_d);
            check("ctrl",       256'(ctrl_out),  256'(last_c));
            check("no_bcnt_we", 256'(x_bcnt_we), 256'(0));
            if (k < nw - 1) check("rdy_held", 256'(rdy[ch]), 256'(1));
            else            check("rdy_drop", 256'(rdy[ch]), 256'(0));
        end
        vld[ch] = 1'b0;
        step();
        check("desc_we_low",  256'(x_we),       256'(0));
        check("desc_bcnt_we", 256'(x_bcnt_we),  256'(1));
        check("desc_bytes",   256'(x_byte_cnt), 256'(b));
        check("desc_no_done", 256'(done[ch]),   256'(0));
        step();
        check("done_pulse",   256'(done[ch]),   256'(1));
        check("done_other",   256'(done[1-ch]), 256'(0));
        check("done_bcnt_we", 256'(x_bcnt_we),  256'(0));
        check("done_idle",    256'(busy),       256'(0));
        req[ch] = 1'b0;
    endtask

    task automatic reject(input int ch, input logic [31:0] b);
        bcnt[ch] = b;
        req[ch]  = 1'b1;
        step();
        check("rej_busy",      256'(busy),    256'(1));
        check("rej_err_early", 256'(err[ch]), 256'(0));
        step();
        check("rej_err",       256'(err[ch]),   256'(1));
        check("rej_err_other", 256'(err[1-ch]), 256'(0));
        check("rej_no_we",     256'(x_we),      256'(0));
        check("rej_no_bcnt",   256'(x_bcnt_we), 256'(0));
        check("rej_no_done",   256'(done[ch]),  256'(0));
        req[ch] = 1'b0;
        step();
        check("rej_err_pulse", 256'(err[ch]),   256'(0));
        check("rej_no_bcnt2",  256'(x_bcnt_we), 256'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int waited;
        reset      = 1'b1;
        data_usedw = '0;
        bcnt_usedw = '0;
        for (int c = 0; c < 2; c++) begin
            req[c]  = 1'b0;
            bcnt[c] = '0;
            din[c]  = '0;
            cin[c]  = '0;
            vld[c]  = 1'b0;
        end
        step();
        step();
        check_reset_outputs("rst");
        reset = 1'b0;
        step();

        // Single ch0 frame of 64 bytes: x_we at t+1,t+2, descriptor t+3, done t+4.
        serve(0, 32'd64, 2, 1'b0, 2);
        step();
        check("done_one_cycle", 256'(done[0]), 256'(0));

        // Simultaneous requests from reset: ch0, then ch1 (ch0 re-requests at once), then ch0.
        do_reset();
        req[1]  = 1'b1;
        bcnt[1] = 32'd33;
        serve(0, 32'd33, 2, 1'b0, 2);
        req[0]  = 1'b1;
        bcnt[0] = 32'd96;
        serve(1, 32'd33, 2, 1'b0, 2);
        serve(0, 32'd96, 3, 1'b0, 2);

        // Illegal lengths, then a tie proving rr_last moved to ch0; also single-word and max-length frames.
        do_reset();
        reject(0, 32'd0);
        reject(0, 32'd9601);
        req[0]  = 1'b1;
        bcnt[0] = 32'd32;
        serve(1, 32'd9600, 300, 1'b0, 2);
        serve(0, 32'd32, 1, 1'b0, 2);

        // Room hold: data FIFO too full, then byte-count FIFO too full, then both fit.
        data_usedw = 11'd1018;
        req[0]     = 1'b1;
        bcnt[0]    = 32'd128;
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_data_rdy", 256'(rdy[0]), 256'(0));
            check("hold_data_we",  256'(x_we),   256'(0));
            check("hold_busy",     256'(busy),   256'(1));
        end
        data_usedw = 11'd1016;
        bcnt_usedw = 9'd255;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_bcnt_rdy", 256'(rdy[0]), 256'(0));
        end
        bcnt_usedw = 9'd254;
        serve(0, 32'd128, 4, 1'b0, 1);
        data_usedw = '0;
        bcnt_usedw = '0;

        // vld gaps on a 3-word ch1 frame; upper flag bits ride along in the descriptor.
        serve(1, 32'hA500_0060, 3, 1'b1, 2);

        // Reset after one of three words: frame abandoned, no done or descriptor.
        frame_no++;
        req[0]  = 1'b1;
        bcnt[0] = 32'd80;
        waited  = 0;
        while (!rdy[0] && waited < 20) begin
            step();
            waited++;
        end
        check("abort_grant", 256'(rdy[0]), 256'(1));
        din[0] = word_of(0, 0);
        cin[0] = ctrl_of(0, 0);
        vld[0] = 1'b1;
        step();
        check("abort_first_we", 256'(x_we), 256'(1));
        din[0] = word_of(0, 1);
        reset  = 1'b1;
        step();
        check_reset_outputs("abort");
        reset  = 1'b0;
        req[0] = 1'b0;
        vld[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort_quiet", 256'({done[0], x_bcnt_we, x_we, busy}), 256'(0));
        end
        serve(1, 32'd64, 2, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
